ftoi_wb_queue: RTL and testbench
================================

Name: ftoi_wb_queue

Overview:
- Registered writeback queue directly downstream of the combinational float-to-int converter.
- Accepts converter results tagged with an integer destination register, classifies each source float for exception flags, and buffers them in a FIFO.
- Drains the FIFO to the integer register-file write port with a valid/ready handshake.
- Keeps a sticky exception status bit for the FPU control/status register.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- TAGW, 6, destination register tag width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  converter result presented.
- in_ready  out  1  queue can accept this cycle.
- in_tag  in  TAGW  destination integer register.
- in_x  in  32  source IEEE-754 single (the converter's input).
- in_y  in  32  converter's 32-bit signed result.
- out_valid  out  1  head entry valid.
- out_ready  in  1  register file accepts the head.
- out_tag  out  TAGW  head destination tag.
- out_data  out  32  head integer result.
- out_nv  out  1  head invalid flag (source was Inf/NaN).
- out_of  out  1  head overflow flag (result saturated).
- sticky_exc  out  1  OR of all flags pushed since last clear.
- clr_sticky  in  1  clear sticky_exc.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (asynchronous, immediate, including mid-transfer):
  - rd_ptr = wr_ptr = count = 0; out_valid = 0; sticky_exc = 0.
  - Entry storage is not cleared.
  - out_tag/out_data/out_nv/out_of are don't-care while out_valid = 0.
- Handshake signals:
  - in_ready = (count != DEPTH). It depends only on registered state, never on out_ready.
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - out_valid = (count != 0).
  - The head outputs are read from registered storage at rd_ptr, with no combinational path from the in_* ports.
- Latency: a pushed entry becomes visible on out_* in the cycle after the push edge (one cycle minimum). There is no bypass, even when empty.
- Flag classification at push, with e = in_x[30:23] and m = in_x[22:0]:
  - nv = (e == 8'hFF).
  - of = !nv & (e >= 8'd158) & (in_x != 32'hCF000000).
  - Exactly -2^31 is representable, so it is not overflow.
  - e ≤ 125 (magnitude < 0.5) raises no flag.
  - in_y is stored unmodified; the queue never alters the data.
- Pointers and count:
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH naturally.
  - count += push - pop.
  - Push and pop in the same cycle leave count unchanged and are legal at any occupancy 1..DEPTH-1.
  - When full, in_ready = 0, so a same-cycle pop does not admit a push; the push is admitted the following cycle.
  - When empty, pop cannot occur.
  - An out_ready pulse while out_valid = 0 has no effect.
- Sticky bit:
  - Next value = (sticky_exc & !clr_sticky) | (push & (nv | of)).
  - A flagged push in the same cycle as clr_sticky leaves sticky = 1 (set wins).
- Ordering: strict FIFO; tags are never reordered or dropped.
- Assertions for verification:
  - count ≤ DEPTH.
  - No push while full.
  - No pop while empty.

Test Plan:
- Single entry: reset, then push tag=5, x=0x3FC00000, y=0x00000002. Next cycle out_valid=1, out_tag=5, out_data=2, nv=0, of=0, count=1. Pulse out_ready → count=0, out_valid=0.
- Flags: push x=0x7FC00000 (NaN) → out_nv=1, of=0. Push x=0x4F000000 (2^31) → of=1. Push x=0xCF000000 → of=0. sticky_exc=1 after the first push.
- Fill/drain with DEPTH=4 and out_ready=0: push tags 1..5 back-to-back. Tags 1–4 are accepted; in_ready=0 while count=4. Raise out_ready: tag 1 pops, tag 5 is accepted the next cycle. Output order is 1,2,3,4,5.
- Wrap under throughput: hold in_valid=out_ready=1 for 20 cycles with incrementing tags. After the first cycle count stays 1, every tag appears once and in order, and the pointers wrap 5 times.
- Sticky race: clr_sticky=1 in the same cycle as a NaN push → sticky_exc=1. clr_sticky alone next cycle → sticky_exc=0.
- Async reset: with count=3, assert rst between clock edges → count=0, out_valid=0, sticky=0 immediately. After release, the first push returns its own data with no stale entries.

Source files
------------

// File: rtl/ftoi_wb_queue.sv
// Writeback FIFO behind the float-to-int converter: tags each result with
// NV/OF exception flags, drains it to the integer register file, and keeps a sticky status bit.
module ftoi_wb_queue #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [TAGW-1:0]          in_tag,
    input  logic [31:0]              in_x,
    input  logic [31:0]              in_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TAGW-1:0]          out_tag,
    output logic [31:0]              out_data,
    output logic                     out_nv,
    output logic                     out_of,
    output logic                     sticky_exc,
    input  logic                     clr_sticky,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [TAGW-1:0] r_tag  [DEPTH];
    logic [31:0]     r_data [DEPTH];
    logic            r_nv   [DEPTH];
    logic            r_of   [DEPTH];

    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_sticky;

    logic            w_push;
    logic            w_pop;
    logic            w_nv;
    logic            w_of;

    function automatic logic flag_nv(input logic [31:0] x);
        return (x[30:23] == 8'hFF);
    endfunction

    // -2^31 is the one exponent-158 value that still fits in int32.
    function automatic logic flag_of(input logic [31:0] x);
        return !flag_nv(x) && (x[30:23] >= 8'd158) && (x != 32'hCF000000);
    endfunction

    assign w_nv      = flag_nv(in_x);
    assign w_of      = flag_of(in_x);

    assign in_ready  = (r_count != CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign out_tag    = r_tag[r_rd_ptr];
    assign out_data   = r_data[r_rd_ptr];
    assign out_nv     = r_nv[r_rd_ptr];
    assign out_of     = r_of[r_rd_ptr];
    assign sticky_exc = r_sticky;
    assign count      = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_sticky <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
            // Set wins over clear when both happen in one cycle.
            r_sticky <= (r_sticky && !clr_sticky) || (w_push && (w_nv || w_of));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag[r_wr_ptr]  <= in_tag;
            r_data[r_wr_ptr] <= in_y;
            r_nv[r_wr_ptr]   <= w_nv;
            r_of[r_wr_ptr]   <= w_of;
        end
    end

endmodule

// File: tb/tb_ftoi_wb_queue.sv
// Directed bench for ftoi_wb_queue: flag table plus fill/drain, throughput,
// sticky race and asynchronous reset sequences.
module tb_ftoi_wb_queue;

    localparam int DEPTH = 4;
    localparam int TAGW  = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready;
    logic [TAGW-1:0] in_tag;
    logic [31:0]     in_x, in_y;
    logic            out_valid, out_ready;
    logic [TAGW-1:0] out_tag;
    logic [31:0]     out_data;
    logic            out_nv, out_of;
    logic            sticky_exc, clr_sticky;
    logic [2:0]      count;

    int checks = 0;
    int errors = 0;

    ftoi_wb_queue #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
        .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_data(out_data), .out_nv(out_nv), .out_of(out_of),
        .sticky_exc(sticky_exc), .clr_sticky(clr_sticky), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TAGW-1:0] tag;
        logic [31:0]     x;
        logic [31:0]     y;
        logic            nv;
        logic            of;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [TAGW-1:0] t, input logic [31:0] x, input logic [31:0] y);
        in_valid = 1'b1; in_tag = t; in_x = x; in_y = y;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop1();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    // Occupancy bound watched continuously outside reset.
    always @(negedge clk) begin
        if (rst === 1'b0 && count > 3'(DEPTH)) begin
            errors++;
            $display("FAIL count_bound: got %0d expected <= %0d", count, DEPTH);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{6'd5,  32'h3FC00000, 32'h00000002, 1'b0, 1'b0};
        vecs[1] = '{6'd6,  32'h7FC00000, 32'h80000000, 1'b1, 1'b0};
        vecs[2] = '{6'd7,  32'h4F000000, 32'h7FFFFFFF, 1'b0, 1'b1};
        vecs[3] = '{6'd8,  32'hCF000000, 32'h80000000, 1'b0, 1'b0};
        vecs[4] = '{6'd9,  32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0};
        vecs[5] = '{6'd10, 32'hFF800000, 32'h80000000, 1'b1, 1'b0};
        vecs[6] = '{6'd11, 32'h3E800000, 32'h00000000, 1'b0, 1'b0};
        vecs[7] = '{6'd12, 32'hCF000001, 32'h80000000, 1'b0, 1'b1};
        vecs[8] = '{6'd13, 32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0};
        vecs[9] = '{6'd14, 32'h00000000, 32'h00000000, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_tag = '0; in_x = '0; in_y = '0;
        out_ready = 1'b0; clr_sticky = 1'b0;
        step(); step();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sticky", 32'(sticky_exc), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        step();

        // Pop request while empty must not disturb state.
        pop1();
        chk("empty_pop_count", 32'(count), 32'd0);
        chk("empty_pop_valid", 32'(out_valid), 32'd0);

        // Single entries with flag classification.
        for (int i = 0; i < 10; i++) begin
            push1(vecs[i].tag, vecs[i].x, vecs[i].y);
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_tag", i), 32'(out_tag), 32'(vecs[i].tag));
            chk($sformatf("v%0d_data", i), out_data, vecs[i].y);
            chk($sformatf("v%0d_nv", i), 32'(out_nv), 32'(vecs[i].nv));
            chk($sformatf("v%0d_of", i), 32'(out_of), 32'(vecs[i].of));
            chk($sformatf("v%0d_count", i), 32'(count), 32'd1);
            if (i == 0) chk("v0_sticky", 32'(sticky_exc), 32'd0);
            if (i == 1) chk("v1_sticky", 32'(sticky_exc), 32'd1);
            pop1();
            chk($sformatf("v%0d_popped", i), 32'(count), 32'd0);
            chk($sformatf("v%0d_empty", i), 32'(out_valid), 32'd0);
        end

        // Fill to full with out_ready low, then pop while tag 5 waits.
        for (int t = 1; t <= 4; t++) push1(6'(t), 32'h3F800000, 32'(t * 16));
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_tag = 6'd5; in_x = 32'h3F800000; in_y = 32'd80;
        out_ready = 1'b1;
        chk("full_head", 32'(out_tag), 32'd1);
        step();
        out_ready = 1'b0;
        chk("full_pop_blocks_push", 32'(count), 32'd3);
        chk("full_in_ready_back", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("refill_count", 32'(count), 32'd4);
        for (int t = 2; t <= 5; t++) begin
            chk($sformatf("drain_tag%0d", t), 32'(out_tag), 32'(t));
            chk($sformatf("drain_data%0d", t), out_data, 32'(t * 16));
            pop1();
        end
        chk("drain_empty", 32'(count), 32'd0);

        // Continuous push+pop across several pointer wraps.
        in_valid = 1'b1; out_ready = 1'b1; in_x = 32'h40000000;
        for (int i = 0; i < 20; i++) begin
            in_tag = 6'(10 + i); in_y = 32'(1000 + i);
            if (i > 0) begin
                chk($sformatf("thru_count%0d", i), 32'(count), 32'd1);
                chk($sformatf("thru_tag%0d", i), 32'(out_tag), 32'(10 + i - 1));
                chk($sformatf("thru_data%0d", i), out_data, 32'(1000 + i - 1));
            end
            step();
        end
        in_valid = 1'b0;
        chk("thru_last_tag", 32'(out_tag), 32'd29);
        chk("thru_last_count", 32'(count), 32'd1);
        step();
        out_ready = 1'b0;
        chk("thru_drained", 32'(count), 32'd0);

        // Sticky: clear, then clear racing a NaN push, then clear alone.
        clr_sticky = 1'b1;
        step();
        chk("sticky_cleared", 32'(sticky_exc), 32'd0);
        push1(6'd33, 32'h7FC00000, 32'd0);
        chk("sticky_set_wins", 32'(sticky_exc), 32'd1);
        step();
        clr_sticky = 1'b0;
        chk("sticky_clear_alone", 32'(sticky_exc), 32'd0);
        pop1();
        chk("sticky_popped", 32'(count), 32'd0);

        // Asynchronous reset between edges with three entries queued.
        push1(6'd40, 32'h7F800000, 32'hDEAD0000);
        push1(6'd41, 32'h3F800000, 32'hDEAD0001);
        push1(6'd42, 32'h3F800000, 32'hDEAD0002);
        chk("pre_rst_count", 32'(count), 32'd3);
        chk("pre_rst_sticky", 32'(sticky_exc), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_sticky", 32'(sticky_exc), 32'd0);
        #1 rst = 1'b0;
        step();
        push1(6'd7, 32'h3FC00000, 32'h00001234);
        chk("post_rst_tag", 32'(out_tag), 32'd7);
        chk("post_rst_data", out_data, 32'h00001234);
        chk("post_rst_count", 32'(count), 32'd1);
        pop1();
        chk("post_rst_empty", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
